// File: rtl/npc_pkg.sv
// Shared types and constants for the writeback/commit slice.
// States, load funct3 encodings and default datapath widths.
package npc_pkg;

  localparam int XLEN    = 64;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 64;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_COMMIT   = 2'd2
  } wb_state_t;

  localparam logic [2:0] LOAD_FN_LB  = 3'b000;
  localparam logic [2:0] LOAD_FN_LH  = 3'b001;
  localparam logic [2:0] LOAD_FN_LW  = 3'b010;
  localparam logic [2:0] LOAD_FN_LD  = 3'b011;
  localparam logic [2:0] LOAD_FN_LBU = 3'b100;
  localparam logic [2:0] LOAD_FN_LHU = 3'b101;
  localparam logic [2:0] LOAD_FN_LWU = 3'b110;
  localparam logic [2:0] LOAD_FN_NA  = 3'b111;

endpackage

// File: rtl/wbu_load_align.sv
// Shifts the LSU doubleword down to the load address and
// sign/zero-extends it according to the load funct3.
module wbu_load_align
  import npc_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rdata,
  input  logic [2:0]   fn,
  input  logic [2:0]   addr_lo,
  output logic [W-1:0] data
);

  logic [W-1:0] d;

  // misaligned offsets are not trapped here; bytes fall off the top
  assign d = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = '0;
    unique case (fn)
      LOAD_FN_LB:  data = {{(W-8){d[7]}}, d[7:0]};
      LOAD_FN_LH:  data = {{(W-16){d[15]}}, d[15:0]};
      LOAD_FN_LW:  data = {{(W-32){d[31]}}, d[31:0]};
      LOAD_FN_LD:  data = d;
      LOAD_FN_LBU: data = {{(W-8){1'b0}}, d[7:0]};
      LOAD_FN_LHU: data = {{(W-16){1'b0}}, d[15:0]};
      LOAD_FN_LWU: data = {{(W-32){1'b0}}, d[31:0]};
      LOAD_FN_NA:  data = '0;
    endcase
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: takes one retired op from execute, waits
// for load data when needed, then drives the regfile port for a cycle.
module wb_commit_unit
  import npc_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_AW,
  parameter int PC_WIDTH   = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_fn,
  input  logic [2:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  reg_wen,
  output logic [ADDR_WIDTH-1:0] reg_rd,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  retire_valid,
  output logic [PC_WIDTH-1:0]   retire_pc,
  output logic [CNT_W-1:0]      retire_cnt
);

  wb_state_t state, state_nx;

  logic [PC_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q;
  logic [2:0]            fn_q;
  logic [2:0]            lo_q;

  logic hs, alu_done, mem_done, commit;
  logic wait_mem;

  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] c_data;
  logic [ADDR_WIDTH-1:0] c_rd;
  logic [PC_WIDTH-1:0]   c_pc;
  logic                  c_wen;

  assign wait_mem = (state == WB_WAIT_MEM);
  assign in_ready = ~wait_mem;
  assign hs       = in_valid & in_ready;
  assign alu_done = hs & ~in_is_load;
  assign mem_done = wait_mem & mem_rvalid;
  assign commit   = alu_done | mem_done;

  wbu_load_align #(
    .W (DATA_WIDTH)
  ) u_align (
    .rdata   (mem_rdata),
    .fn      (fn_q),
    .addr_lo (lo_q),
    .data    (ld_data)
  );

  // a load commits from the captured fields, an ALU op straight from input
  assign c_data = mem_done ? ld_data : in_alu_result;
  assign c_rd   = mem_done ? rd_q    : in_rd;
  assign c_pc   = mem_done ? pc_q    : in_pc;
  assign c_wen  = mem_done ? wen_q   : in_wen;

  always_comb begin
    state_nx = WB_IDLE;
    unique case (1'b1)
      mem_done:               state_nx = WB_COMMIT;
      wait_mem & ~mem_rvalid: state_nx = WB_WAIT_MEM;
      hs & in_is_load:        state_nx = WB_WAIT_MEM;
      alu_done:               state_nx = WB_COMMIT;
      default:                state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_IDLE;
      pc_q  <= '0;
      rd_q  <= '0;
      wen_q <= 1'b0;
      fn_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        pc_q  <= in_pc;
        rd_q  <= in_rd;
        wen_q <= in_wen;
        fn_q  <= in_load_fn;
        lo_q  <= in_addr_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wen      <= 1'b0;
      reg_rd       <= '0;
      reg_wdata    <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_cnt   <= '0;
    end else begin
      reg_wen      <= commit & c_wen & (c_rd != '0);
      retire_valid <= commit;
      if (commit) begin
        reg_rd     <= c_rd;
        reg_wdata  <= c_data;
        retire_pc  <= c_pc;
        retire_cnt <= retire_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit with a per-cycle reference
// model plus literal expectations for the listed scenarios.
module tb_wb_commit_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [63:0] in_alu_result;
  logic        in_is_load;
  logic [2:0]  in_load_fn;
  logic [2:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        reg_wen;
  logic [4:0]  reg_rd;
  logic [63:0] reg_wdata;
  logic        retire_valid;
  logic [63:0] retire_pc;
  logic [63:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  wb_commit_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .in_alu_result (in_alu_result),
    .in_is_load    (in_is_load),
    .in_load_fn    (in_load_fn),
    .in_addr_lo    (in_addr_lo),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .reg_wen       (reg_wen),
    .reg_rd        (reg_rd),
    .reg_wdata     (reg_wdata),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference load result: pick width, mask, optionally sign-fill.
  function automatic logic [63:0] ref_align(
    input logic [63:0] r,
    input logic [2:0]  fn,
    input logic [2:0]  lo
  );
    logic [63:0] d, m;
    int nb;
    if (fn == 3'b111) return 64'd0;
    d = r >> (8 * lo);
    case (fn[1:0])
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 8;
    endcase
    m = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    d = d & m;
    if (!fn[2] && nb < 8 && d[8*nb-1]) d = d | ~m;
    return d;
  endfunction

  // Model: a result appears the cycle after its op is accepted
  // (ALU) or after its load data arrives (load).
  logic        m_pend = 0;
  logic [4:0]  p_rd = 0;
  logic        p_wen = 0;
  logic [63:0] p_pc = 0;
  logic [2:0]  p_fn = 0, p_lo = 0;
  logic        m_rv = 0, m_wen = 0;
  logic [4:0]  m_rd = 0;
  logic [63:0] m_wd = 0, m_pc = 0, m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    logic        c;
    logic [4:0]  crd;
    logic        cwen;
    logic [63:0] cpc, cwd;
    if (rst) begin
      m_pend = 0; m_rv = 0; m_wen = 0;
      m_rd = 0; m_wd = 0; m_pc = 0; m_cnt = 0;
    end else begin
      c = 0; crd = 0; cwen = 0; cpc = 0; cwd = 0;
      if (m_pend) begin
        if (mem_rvalid) begin
          m_pend = 0;
          c = 1; crd = p_rd; cwen = p_wen; cpc = p_pc;
          cwd = ref_align(mem_rdata, p_fn, p_lo);
        end
      end else if (in_valid) begin
        if (in_is_load) begin
          m_pend = 1;
          p_rd = in_rd; p_wen = in_wen; p_pc = in_pc;
          p_fn = in_load_fn; p_lo = in_addr_lo;
        end else begin
          c = 1; crd = in_rd; cwen = in_wen;
          cpc = in_pc; cwd = in_alu_result;
        end
      end
      m_rv = c;
      m_wen = c && cwen && (crd != 0);
      if (c) begin
        m_rd = crd; m_wd = cwd; m_pc = cpc;
        m_cnt = m_cnt + 64'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready", {63'd0, in_ready}, {63'd0, !m_pend});
    chk("m_rv", {63'd0, retire_valid}, {63'd0, m_rv});
    chk("m_wen", {63'd0, reg_wen}, {63'd0, m_wen});
    chk("m_cnt", retire_cnt, m_cnt);
    if (m_rv) begin
      chk("m_rd", {59'd0, reg_rd}, {59'd0, m_rd});
      chk("m_wd", reg_wdata, m_wd);
      chk("m_pc", retire_pc, m_pc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd,
                     input logic [63:0] v,
                     input logic [63:0] pc,
                     input logic wen);
    in_valid = 1; in_is_load = 0;
    in_rd = rd; in_alu_result = v;
    in_pc = pc; in_wen = wen;
  endtask

  task automatic ld(input logic [4:0] rd,
                    input logic [2:0] fn,
                    input logic [2:0] lo,
                    input logic [63:0] pc);
    in_valid = 1; in_is_load = 1; in_wen = 1;
    in_rd = rd; in_load_fn = fn;
    in_addr_lo = lo; in_pc = pc;
    in_alu_result = 64'hDEAD;
  endtask

  int ecnt = 0;

  task automatic do_load(input logic [2:0] fn,
                         input logic [2:0] lo,
                         input logic [63:0] rd_data,
                         input logic [63:0] exp,
                         input int gap);
    ld(5'd9, fn, lo, 64'h400 + 64'(fn));
    tick;
    in_valid = 0;
    for (int g = 0; g < gap; g++) begin
      chk("ld_busy", {63'd0, in_ready}, 64'd0);
      tick;
    end
    chk("ld_wait_rv", {63'd0, retire_valid}, 64'd0);
    mem_rvalid = 1; mem_rdata = rd_data;
    tick;
    mem_rvalid = 0;
    ecnt++;
    chk("ld_rv", {63'd0, retire_valid}, 64'd1);
    chk("ld_data", reg_wdata, exp);
    chk("ld_cnt", retire_cnt, 64'(ecnt));
    chk("ld_ready", {63'd0, in_ready}, 64'd1);
    tick;
  endtask

  initial begin
    rst = 1;
    in_valid = 0; in_pc = 0; in_rd = 0; in_wen = 0;
    in_alu_result = 0; in_is_load = 0;
    in_load_fn = 0; in_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_rv", {63'd0, retire_valid}, 64'd0);
    chk("rst_wen", {63'd0, reg_wen}, 64'd0);
    chk("rst_cnt", retire_cnt, 64'd0);
    tick;

    alu(5'd5, 64'h1234, 64'h100, 1'b1);
    tick;
    in_valid = 0;
    ecnt++;
    chk("alu_wen", {63'd0, reg_wen}, 64'd1);
    chk("alu_rd", {59'd0, reg_rd}, 64'd5);
    chk("alu_wd", reg_wdata, 64'h1234);
    chk("alu_cnt", retire_cnt, 64'd1);
    chk("alu_pc", retire_pc, 64'h100);
    tick;
    chk("alu_one", {63'd0, retire_valid}, 64'd0);

    for (int i = 1; i <= 3; i++) begin
      alu(5'(i), 64'(i * 16), 64'(64'h200 + 4 * i), 1'b1);
      tick;
      ecnt++;
      chk("b2b_rv", {63'd0, retire_valid}, 64'd1);
      chk("b2b_wd", reg_wdata, 64'(i * 16));
      chk("b2b_cnt", retire_cnt, 64'(ecnt));
    end
    in_valid = 0;
    tick;
    chk("b2b_end", {63'd0, retire_valid}, 64'd0);

    do_load(3'b000, 3'd3, 64'h00000000_80000000,
            64'hFFFFFFFF_FFFFFF80, 1);
    do_load(3'b101, 3'd6, 64'hBEEF0000_00000000,
            64'h00000000_0000BEEF, 3);
    do_load(3'b010, 3'd4, 64'h80000001_00000000,
            64'hFFFFFFFF_80000001, 0);
    do_load(3'b011, 3'd0, 64'h01234567_89ABCDEF,
            64'h01234567_89ABCDEF, 2);
    do_load(3'b100, 3'd1, 64'h00000000_0000FF00,
            64'h00000000_000000FF, 1);
    do_load(3'b110, 3'd4, 64'hF0000000_00000000,
            64'h00000000_F0000000, 1);
    do_load(3'b001, 3'd2, 64'h00000000_80010000,
            64'hFFFFFFFF_FFFF8001, 1);
    do_load(3'b111, 3'd0, 64'hFFFFFFFF_FFFFFFFF,
            64'd0, 1);

    alu(5'd0, 64'h55, 64'h500, 1'b1);
    tick;
    in_valid = 0;
    ecnt++;
    chk("x0_rv", {63'd0, retire_valid}, 64'd1);
    chk("x0_wen", {63'd0, reg_wen}, 64'd0);
    mem_rvalid = 1; mem_rdata = 64'h77;
    tick;
    mem_rvalid = 0;
    tick;
    chk("spur_rv", {63'd0, retire_valid}, 64'd0);
    chk("spur_cnt", retire_cnt, 64'(ecnt));

    alu(5'd4, 64'hA, 64'h600, 1'b1);
    tick;
    ld(5'd6, 3'b011, 3'd0, 64'h604);
    tick;
    in_valid = 0;
    tick;
    chk("rw_busy", {63'd0, in_ready}, 64'd0);
    #2 rst = 1;
    #1;
    chk("rw_ready", {63'd0, in_ready}, 64'd1);
    chk("rw_cnt", retire_cnt, 64'd0);
    chk("rw_wen", {63'd0, reg_wen}, 64'd0);
    chk("rw_rv", {63'd0, retire_valid}, 64'd0);
    tick;
    rst = 0;
    mem_rvalid = 1; mem_rdata = 64'h99;
    tick;
    mem_rvalid = 0;
    chk("rw_drop_rv", {63'd0, retire_valid}, 64'd0);
    chk("rw_drop_cnt", retire_cnt, 64'd0);
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
